// File: rtl/axis_bus_mux_pkt.sv
// Packet-aware N-to-1 AXI-Stream mux with a one-stage output register.
// Optional AXIS_MUX_PKT_CNT_EN adds a 32-bit output packet counter.
module axis_bus_mux_pkt #(
  parameter int NUM_CH = 12,
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int SEL_W  = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [SEL_W-1:0]         bus_sel,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [KEEP_W-1:0]        m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     busy,
`ifdef AXIS_MUX_PKT_CNT_EN
  output logic [31:0]              pkt_cnt,
`endif
  output logic [SEL_W-2:0]         active_ch
);

  localparam int IW = SEL_W - 1;
  localparam logic [SEL_W-1:0] NCH = SEL_W'(NUM_CH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PASS = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     active_q, active_d;
  logic              mvalid_q, mvalid_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic [KEEP_W-1:0] mkeep_q, mkeep_d;
  logic              mlast_q, mlast_d;

  logic              vld_sel;
  logic              last_sel;
  logic [DATA_W-1:0] data_sel;
  logic [KEEP_W-1:0] keep_sel;
  logic              ready_sel;
  logic              accept;
  logic              in_range;

  // Route the locked channel's beat and drive its ready only
  always_comb begin
    vld_sel  = 1'b0;
    last_sel = 1'b0;
    data_sel = '0;
    keep_sel = '0;
    // Ready is gated by reset so no beat is taken on a reset cycle
    ready_sel = aresetn && (state_q == PASS) &&
                (!mvalid_q || m_axis_tready);
    s_axis_tready = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (active_q == IW'(n)) begin
        vld_sel  = s_axis_tvalid[n];
        last_sel = s_axis_tlast[n];
        data_sel = s_axis_tdata[n*DATA_W +: DATA_W];
        keep_sel = s_axis_tkeep[n*KEEP_W +: KEEP_W];
        s_axis_tready[n] = ready_sel;
      end
    end
    accept = ready_sel && vld_sel;
  end

  assign in_range = {1'b0, bus_sel[IW-1:0]} < NCH;

  // Lock a channel in IDLE; release it when its tlast is accepted
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus_sel[SEL_W-1] && in_range) begin
          state_d  = PASS;
          active_d = bus_sel[IW-1:0];
        end
      end
      default: begin
        if (accept && last_sel) state_d = IDLE;
      end
    endcase
  end

  // Output slice: reload on accept, drain on handshake
  always_comb begin
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    mkeep_d  = mkeep_q;
    mlast_d  = mlast_q;
    if (accept) begin
      mvalid_d = 1'b1;
      mdata_d  = data_sel;
      mkeep_d  = keep_sel;
      mlast_d  = last_sel;
    end else if (mvalid_q && m_axis_tready) begin
      mvalid_d = 1'b0;
    end
  end

  // State and slice registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      active_q <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mkeep_q  <= '0;
      mlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      mkeep_q  <= mkeep_d;
      mlast_q  <= mlast_d;
    end
  end

`ifdef AXIS_MUX_PKT_CNT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (mvalid_q && m_axis_tready && mlast_q)
      pkt_cnt_d = pkt_cnt_q + 32'd1;
  end

  // Count completed output packets, wrapping at 2^32
  always_ff @(posedge aclk) begin
    if (!aresetn) pkt_cnt_q <= '0;
    else          pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

  assign m_axis_tvalid = mvalid_q;
  assign m_axis_tdata  = mdata_q;
  assign m_axis_tkeep  = mkeep_q;
  assign m_axis_tlast  = mlast_q;
  assign busy          = (state_q == PASS);
  assign active_ch     = active_q;

endmodule

// File: tb/tb_axis_bus_mux_pkt.sv
// Directed bench for axis_bus_mux_pkt.
// Vector table plus hand-written stall and counter sequences.
module tb_axis_bus_mux_pkt;

  localparam int NCH = 12;
  localparam int DW  = 32;
  localparam int KW  = 4;
  localparam int SW  = 8;

  logic              clk;
  logic              rstn;
  logic [SW-1:0]     bus_sel;
  logic [NCH-1:0]    s_tvalid;
  logic [NCH-1:0]    s_tready;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH*KW-1:0] s_tkeep;
  logic [NCH-1:0]    s_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic              busy;
  logic [SW-2:0]     active_ch;
`ifdef AXIS_MUX_PKT_CNT_EN
  logic [31:0]       pkt_cnt;
`endif

  axis_bus_mux_pkt #(
    .NUM_CH(NCH), .DATA_W(DW), .SEL_W(SW)
  ) dut (
    .aclk(clk),
    .aresetn(rstn),
    .bus_sel(bus_sel),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast),
    .busy(busy),
`ifdef AXIS_MUX_PKT_CNT_EN
    .pkt_cnt(pkt_cnt),
`endif
    .active_ch(active_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           rstn;
    logic [7:0]     sel;
    logic [NCH-1:0] vmask;
    logic [23:0]    data;
    logic           last;
    logic           mrdy;
    logic [NCH-1:0] exp_rdy;
    logic           exp_busy;
    logic [6:0]     exp_ach;
    logic           exp_mv;
    logic [31:0]    exp_md;
    logic           exp_ml;
  } vec_t;

  vec_t tbl[$];
  int   pass_cnt = 0;
  int   total    = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(
    input logic r, input logic [7:0] s, input logic [NCH-1:0] vm,
    input logic [23:0] d, input logic l, input logic mr,
    input logic [NCH-1:0] er, input logic eb, input logic [6:0] ea,
    input logic ev, input logic [31:0] ed, input logic el);
    vec_t v;
    v.rstn = r; v.sel = s; v.vmask = vm; v.data = d;
    v.last = l; v.mrdy = mr; v.exp_rdy = er; v.exp_busy = eb;
    v.exp_ach = ea; v.exp_mv = ev; v.exp_md = ed; v.exp_ml = el;
    return v;
  endfunction

  // Channel n carries {n, payload} and keep n+1
  task automatic drive(input logic [NCH-1:0] vm, input logic [23:0] d,
                       input logic l);
    s_tvalid = vm;
    s_tlast  = {NCH{l}};
    for (int n = 0; n < NCH; n++) begin
      s_tdata[n*DW +: DW] = {8'(n), d};
      s_tkeep[n*KW +: KW] = 4'(n + 1);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tg;
    tg = $sformatf("v%0d", idx);
    rstn     = v.rstn;
    bus_sel  = v.sel;
    m_tready = v.mrdy;
    drive(v.vmask, v.data, v.last);
    #1;
    chk({tg, " s_tready"}, 64'(s_tready), 64'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk({tg, " busy"}, 64'(busy), 64'(v.exp_busy));
    chk({tg, " m_tvalid"}, 64'(m_tvalid), 64'(v.exp_mv));
    if (v.exp_busy)
      chk({tg, " active_ch"}, 64'(active_ch), 64'(v.exp_ach));
    if (v.exp_mv) begin
      chk({tg, " m_tdata"}, 64'(m_tdata), 64'(v.exp_md));
      chk({tg, " m_tlast"}, 64'(m_tlast), 64'(v.exp_ml));
      chk({tg, " m_tkeep"}, 64'(m_tkeep),
          64'(4'(v.exp_md[31:24] + 8'd1)));
    end
  endtask

`ifdef AXIS_MUX_PKT_CNT_EN
  task automatic send_one(input int ch);
    m_tready = 1'b1;
    bus_sel = 8'(128 + ch);
    drive('0, 24'h0, 1'b0);
    @(posedge clk); #1;
    bus_sel = 8'd0;
    drive(NCH'(1) << ch, 24'h5A, 1'b1);
    @(posedge clk); #1;
    drive('0, 24'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask
`endif

  logic        mv_m, ml_m, pass_m, exp_r, acc, hs, lst;
  logic [31:0] md_m;
  int          sent, got, cyc;

  initial begin
    rstn = 1'b0; bus_sel = '0; m_tready = 1'b0;
    drive('0, 24'h0, 1'b0);

    // Test 1: ch3, 4 beats
    tbl.push_back(mk(1,131,12'h000,24'h00,0,1,12'h000,1,3,0,0,0));
    tbl.push_back(mk(1,131,12'h008,24'h11,0,1,12'h008,1,3,1,32'h03000011,0));
    tbl.push_back(mk(1,131,12'h008,24'h22,0,1,12'h008,1,3,1,32'h03000022,0));
    tbl.push_back(mk(1,131,12'h008,24'h33,0,1,12'h008,1,3,1,32'h03000033,0));
    tbl.push_back(mk(1,131,12'h008,24'h44,1,1,12'h008,0,0,1,32'h03000044,1));
    tbl.push_back(mk(1,0,12'h000,24'h00,0,1,12'h000,0,0,0,0,0));
    // Test 2: ch5 locked, select moves to ch2 mid-packet
    tbl.push_back(mk(1,133,12'h000,24'h00,0,1,12'h000,1,5,0,0,0));
    tbl.push_back(mk(1,133,12'h020,24'hA1,0,1,12'h020,1,5,1,32'h050000A1,0));
    tbl.push_back(mk(1,133,12'h020,24'hA2,0,1,12'h020,1,5,1,32'h050000A2,0));
    tbl.push_back(mk(1,130,12'h024,24'hA3,0,1,12'h020,1,5,1,32'h050000A3,0));
    tbl.push_back(mk(1,130,12'h024,24'hA4,1,1,12'h020,0,0,1,32'h050000A4,1));
    tbl.push_back(mk(1,130,12'h004,24'hB1,0,1,12'h000,1,2,0,0,0));
    tbl.push_back(mk(1,130,12'h004,24'hB1,1,1,12'h004,0,0,1,32'h020000B1,1));
    tbl.push_back(mk(1,0,12'h000,24'h00,0,1,12'h000,0,0,0,0,0));
    // Test 3: disabled and out-of-range selects
    tbl.push_back(mk(1,0,12'hFFF,24'h77,0,1,12'h000,0,0,0,0,0));
    tbl.push_back(mk(1,140,12'hFFF,24'h77,0,1,12'h000,0,0,0,0,0));
    tbl.push_back(mk(1,140,12'hFFF,24'h77,1,1,12'h000,0,0,0,0,0));
    tbl.push_back(mk(1,12,12'hFFF,24'h77,1,1,12'h000,0,0,0,0,0));
    // Test 5: reset at beat 3 of a ch7 packet
    tbl.push_back(mk(1,135,12'h000,24'h00,0,1,12'h000,1,7,0,0,0));
    tbl.push_back(mk(1,135,12'h080,24'hC1,0,0,12'h080,1,7,1,32'h070000C1,0));
    tbl.push_back(mk(1,135,12'h080,24'hC2,0,0,12'h000,1,7,1,32'h070000C1,0));
    tbl.push_back(mk(0,135,12'h080,24'hC3,0,0,12'h000,0,0,0,0,0));
    tbl.push_back(mk(1,135,12'h000,24'h00,0,1,12'h000,1,7,0,0,0));
    tbl.push_back(mk(1,135,12'h080,24'hD1,1,1,12'h080,0,0,1,32'h070000D1,1));
    tbl.push_back(mk(1,0,12'h000,24'h00,0,1,12'h000,0,0,0,0,0));

    @(posedge clk); @(posedge clk); #1;
    chk("rst m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst m_tdata", 64'(m_tdata), 64'd0);
    chk("rst m_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst m_tlast", 64'(m_tlast), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst active_ch", 64'(active_ch), 64'd0);
    chk("rst s_tready", 64'(s_tready), 64'd0);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Test 4: ch0 8 beats under 1,0,0 backpressure
    rstn = 1'b1; bus_sel = 8'd128; m_tready = 1'b1;
    drive('0, 24'h0, 1'b0);
    @(posedge clk); #1;
    bus_sel = 8'd0;
    mv_m = 0; ml_m = 0; md_m = '0; pass_m = 1;
    sent = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 80) begin
      m_tready = (cyc % 3 == 0);
      lst = (sent == 7);
      drive((sent < 8) ? 12'h001 : 12'h000, 24'(32'h40 + sent), lst);
      #1;
      exp_r = pass_m && (!mv_m || m_tready);
      chk($sformatf("stall c%0d s_tready", cyc),
          64'(s_tready), 64'({11'b0, exp_r}));
      hs  = mv_m && m_tready;
      acc = exp_r && (sent < 8);
      if (hs) begin
        chk($sformatf("stall beat%0d order", got),
            64'(m_tdata), 64'(32'h40 + got));
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        mv_m = 1; md_m = 32'h40 + sent; ml_m = lst;
        if (lst) pass_m = 0;
        sent++;
      end else if (hs) begin
        mv_m = 0;
      end
      chk($sformatf("stall c%0d m_tvalid", cyc),
          64'(m_tvalid), 64'(mv_m));
      if (mv_m) begin
        chk($sformatf("stall c%0d m_tdata", cyc),
            64'(m_tdata), 64'(md_m));
        chk($sformatf("stall c%0d m_tlast", cyc),
            64'(m_tlast), 64'(ml_m));
      end
      cyc++;
    end
    chk("stall beats delivered", 64'(got), 64'd8);
    chk("stall busy end", 64'(busy), 64'd0);

`ifdef AXIS_MUX_PKT_CNT_EN
    // Test 6: packet counter and wrap
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("cnt reset", 64'(pkt_cnt), 64'd0);
    send_one(1);
    send_one(4);
    send_one(9);
    chk("cnt three", 64'(pkt_cnt), 64'd3);
    @(negedge clk);
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pkt_cnt_q;
    @(posedge clk); #1;
    send_one(6);
    chk("cnt wrap", 64'(pkt_cnt), 64'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
